// File: rtl/button_edge_debounce_pkg.sv
// ---------------------------------------------------------------------------
// button_edge_debounce_pkg : shared FSM state type and default debounce length
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package button_edge_debounce_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 100000;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } state_t;

    // Counter width able to hold 0..cycles-1; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/button_edge_debounce_sync2.sv
// ---------------------------------------------------------------------------
// sync2 : two-flop synchronizer for an asynchronous single-bit input
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule

`default_nettype wire

// File: rtl/button_edge_debounce.sv
// ---------------------------------------------------------------------------
// button_edge_debounce : debounced button level with press/release pulses
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module button_edge_debounce #(
    parameter int DEBOUNCE_CYCLES = button_edge_debounce_pkg::DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic enableEdge,
    output logic releaseEdge,
    output logic btn_level
);

    import button_edge_debounce_pkg::*;

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_s;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             enable_edge_q;
    logic             enable_edge_d;
    logic             release_edge_q;
    logic             release_edge_d;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .i_d (btn_raw),
        .o_q (btn_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_LOW;
            cnt_q          <= '0;
            enable_edge_q  <= 1'b0;
            release_edge_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            enable_edge_q  <= enable_edge_d;
            release_edge_q <= release_edge_d;
        end
    end

    // The counter saturates at CNT_LAST by construction: reaching it always
    // leaves the qualifying state, so it can never wrap.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        enable_edge_d  = 1'b0;
        release_edge_d = 1'b0;
        case (state_q)
            S_LOW: begin
                if (btn_s) begin
                    state_d = S_RISE;
                    cnt_d   = '0;
                end
            end
            S_RISE: begin
                if (!btn_s) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = S_HIGH;
                    cnt_d         = '0;
                    enable_edge_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (!btn_s) begin
                    state_d = S_FALL;
                    cnt_d   = '0;
                end
            end
            S_FALL: begin
                if (btn_s) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d        = S_LOW;
                    cnt_d          = '0;
                    release_edge_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        btn_level = (state_q == S_HIGH) || (state_q == S_FALL);
    end

    assign enableEdge  = enable_edge_q;
    assign releaseEdge = release_edge_q;

endmodule

`default_nettype wire

// File: tb/tb_button_edge_debounce.sv
// ---------------------------------------------------------------------------
// tb_button_edge_debounce : scoreboard bench for button_edge_debounce
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_button_edge_debounce;

    localparam int DC  = 4;
    // Drive at a negedge -> pulse visible at the negedge this many posedges later.
    localparam int LAT = DC + 3;

    typedef struct {
        bit is_rel;
        int cyc;
    } exp_t;

    logic clk     = 1'b0;
    logic rst     = 1'b0;
    logic btn_raw = 1'b0;
    logic enableEdge;
    logic releaseEdge;
    logic btn_level;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    int   n_en       = 0;
    int   n_rel      = 0;

    button_edge_debounce #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .enableEdge  (enableEdge),
        .releaseEdge (releaseEdge),
        .btn_level   (btn_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_pulse(input bit is_rel);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_pulse: got %s at cyc %0d, required none",
                     is_rel ? "releaseEdge" : "enableEdge", cyc);
        end else begin
            e = sb.pop_front();
            if (e.is_rel != is_rel || e.cyc != cyc || btn_level !== !is_rel) begin
                miscompares++;
                $display("FAIL pulse: got rel=%0b cyc=%0d level=%0b, required rel=%0b cyc=%0d level=%0b",
                         is_rel, cyc, btn_level, e.is_rel, e.cyc, !e.is_rel);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT emits a pulse.
    always @(negedge clk) begin
        if (enableEdge && releaseEdge) begin
            vectors++;
            miscompares++;
            $display("FAIL both_edges: got enableEdge=1 releaseEdge=1, required not both");
        end
        if (enableEdge) begin
            n_en++;
            check_pulse(1'b0);
        end
        if (releaseEdge) begin
            n_rel++;
            check_pulse(1'b1);
        end
    end

    task automatic expect_pulse(input bit is_rel);
        sb.push_back('{is_rel, cyc + LAT});
    endtask

    task automatic check(input string name, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0b, required %0b", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 100;
        while (sb.size() != 0 && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s: got %0d pulses still pending, required 0", name, sb.size());
            sb.delete();
        end
        repeat (DC + 4) @(negedge clk);
    endtask

    task automatic drive(input logic v);
        @(negedge clk);
        btn_raw = v;
    endtask

    initial begin
        logic [6:0] bounce;
        int         en0;
        int         rel0;

        #1 rst = 1'b1;
        #1;
        check("reset_enableEdge", enableEdge, 1'b0);
        check("reset_releaseEdge", releaseEdge, 1'b0);
        check("reset_btn_level", btn_level, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Clean press
        drive(1'b1);
        expect_pulse(1'b0);
        drain("clean_press");
        check("press_level", btn_level, 1'b1);

        // Clean release
        drive(1'b0);
        expect_pulse(1'b1);
        drain("clean_release");
        check("release_level", btn_level, 1'b0);

        // Bounce 1,1,0,1,1,1,1: qualification restarts from the 4th sample
        bounce = 7'b1111011;
        en0    = n_en;
        for (int i = 0; i < 7; i++) begin
            drive(bounce[i]);
            if (i == 3) expect_pulse(1'b0);
        end
        drain("bounce_press");
        check_int("bounce_press_count", n_en - en0, 1);

        // Short release glitch while high
        rel0 = n_rel;
        drive(1'b0);
        drive(1'b0);
        drive(1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("glitch_level", btn_level, 1'b1);
        end
        check_int("glitch_release_count", n_rel - rel0, 0);

        drive(1'b0);
        expect_pulse(1'b1);
        drain("release_after_glitch");

        // Long hold
        en0  = n_en;
        rel0 = n_rel;
        drive(1'b1);
        expect_pulse(1'b0);
        repeat (1000) @(negedge clk);
        check_int("hold_press_count", n_en - en0, 1);
        check_int("hold_release_count", n_rel - rel0, 0);
        drain("hold_press");

        // Asynchronous reset while high, button held through deassertion
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_level", btn_level, 1'b0);
        check("async_rst_enableEdge", enableEdge, 1'b0);
        check("async_rst_releaseEdge", releaseEdge, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        expect_pulse(1'b0);
        drain("press_after_reset");

        drive(1'b0);
        expect_pulse(1'b1);
        drain("release_before_midqual");

        // Reset at cnt=2 during qualification
        drive(1'b1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midqual_rst_enableEdge", enableEdge, 1'b0);
        check("midqual_rst_level", btn_level, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        expect_pulse(1'b0);
        drain("midqual_reset_press");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/button_edge_debounce.md
BUTTON_EDGE_DEBOUNCE -- requirements
Module: button_edge_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 100000, the number of consecutive stable synchronized samples required to accept a level change; legal range 2..2^20.
REQ-002 SHALL have port clk input 1, the system clock.
REQ-003 SHALL have port rst input 1, the reset: asynchronous, active-high.
REQ-004 SHALL have port btn_raw input 1, the asynchronous mechanical button level (1 = pressed).
REQ-005 SHALL have port enableEdge output 1, a single-cycle pulse on each accepted press; it feeds the screen timeout counter's enableEdge input.
REQ-006 SHALL have port releaseEdge output 1, a single-cycle pulse on each accepted release.
REQ-007 SHALL have port btn_level output 1, the debounced button level.

Function
REQ-008 SHALL pass btn_raw through a 2-flop synchronizer; the FSM SHALL use only its output, btn_s.
REQ-009 SHALL implement FSM states S_LOW, S_RISE, S_HIGH and S_FALL, plus a counter cnt of width clog2(DEBOUNCE_CYCLES).
REQ-010 In S_LOW, btn_s=1 SHALL go to S_RISE with cnt<=0; otherwise the FSM SHALL stay in S_LOW.
REQ-011 In S_RISE, btn_s=0 SHALL return to S_LOW with no pulse (glitch rejected); btn_s=1 with cnt<DEBOUNCE_CYCLES-1 SHALL increment cnt; btn_s=1 with cnt==DEBOUNCE_CYCLES-1 SHALL go to S_HIGH and register enableEdge=1.
REQ-012 In S_HIGH, btn_s=0 SHALL go to S_FALL with cnt<=0; otherwise the FSM SHALL stay in S_HIGH.
REQ-013 In S_FALL, btn_s=1 SHALL return to S_HIGH with no pulse; btn_s=0 with cnt==DEBOUNCE_CYCLES-1 SHALL go to S_LOW and register releaseEdge=1; otherwise it SHALL increment cnt.
REQ-014 cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-015 enableEdge and releaseEdge SHALL be registered, high for exactly one cycle, and never high in the same cycle.
REQ-016 Latency: with btn_raw first sampled 1 at edge 0 and held stable, enableEdge SHALL be high after edge DEBOUNCE_CYCLES+2 and low after edge DEBOUNCE_CYCLES+3; release latency SHALL be identical.
REQ-017 btn_level SHALL be 1 in S_HIGH and S_FALL and 0 in S_LOW and S_RISE; it SHALL rise in the same cycle enableEdge rises.
REQ-018 A button held continuously SHALL produce exactly one enableEdge until an accepted release.
REQ-019 A bounce shorter than DEBOUNCE_CYCLES samples SHALL restart qualification from cnt=0 on the next qualifying transition.

Reset
REQ-020 While rst=1, the FSM SHALL be S_LOW, cnt=0, both synchronizer flops 0, enableEdge=0, releaseEdge=0 and btn_level=0, independent of clk.
REQ-021 Reset asserted mid-qualification or mid-pulse SHALL abort immediately with no pulse emitted afterwards from the aborted attempt.
REQ-022 If btn_raw=1 at reset release, it SHALL be qualified as a new press and emit enableEdge after the REQ-016 latency.

Structure
REQ-023 A shared package SHALL hold the state enum typedef and the DEBOUNCE_CYCLES default constant.
REQ-024 The 2-flop synchronizer SHALL be a separate sub-module, sync2, with asynchronous active-high reset.
REQ-025 The FSM next-state logic SHALL be combinational and all state SHALL be held in a single always_ff with asynchronous rst.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Clean press: btn_raw 0->1 before edge 0, held -> enableEdge high only between edge 6 and edge 7; btn_level=1 from edge 6.
REQ-027 Bounce: btn_raw pattern 1,1,0,1,1,1,1 across edges -> no pulse until 4 consecutive btn_s=1 samples; exactly one enableEdge.
REQ-028 Release: from S_HIGH, btn_raw 1->0 held -> releaseEdge single pulse 6 edges later; btn_level=0; no enableEdge.
REQ-029 Hold 1000 cycles -> exactly one enableEdge and zero releaseEdge.
REQ-030 Reset mid-qualification: rst asserted at cnt=2 -> all outputs 0 asynchronously; with btn_raw=1 held through rst deassertion, one enableEdge 6 edges after release.
REQ-031 Short release glitch: btn_raw 0 for 2 cycles while in S_HIGH -> no releaseEdge; btn_level stays 1.
